// File: rtl/exec_unit_if.sv
// ============================================================================
//  Module      : exec_unit_if
//  Description : Request/result bundle between a requester and exec_unit.
//                The requester (master) drives start/opcode/src_in; the
//                execution unit (slave) returns status, result and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exec_unit_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] src_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              flag_z;
    logic              flag_c;
    logic              flag_err;

    modport master (
        output start, opcode, src_in,
        input  busy, done, result, flag_z, flag_c, flag_err
    );

    modport slave (
        input  start, opcode, src_in,
        output busy, done, result, flag_z, flag_c, flag_err
    );
endinterface

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
//  Module      : exec_unit
//  Description : Multi-cycle 16-bit execution unit. Operand A and the opcode
//                are taken with START, operand B one cycle later; ALU ops
//                take one EXEC cycle, shifts one cycle per bit, MUL is a
//                16-step shift-add. Optional multiplier: EXEC_UNIT_MUL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_unit #(
    parameter int DATA_W = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    exec_unit_if.slave    bus
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SHL = 3'd5;
    localparam logic [2:0] c_OP_SHR = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GET_B = 2'd1,
        S_EXEC  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_busy;
    logic              w_done;

    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_work;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_load;

    logic [DATA_W-1:0] r_result;
    logic              r_z;
    logic              r_c;
    logic              r_err;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_err;
    logic [DATA_W-1:0] w_work_next;

`ifdef EXEC_UNIT_MUL_EN
    // Product register: upper half accumulates, lower half holds the
    // multiplier bits still to be consumed.
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] w_acc_next;
    logic [DATA_W:0]     w_psum;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode; START is only heard in IDLE and FIN
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_GET_B;
            S_GET_B: begin
                w_busy       = 1'b1;
                w_state_next = S_EXEC;
            end
            S_EXEC:  begin
                w_busy = 1'b1;
                if (r_cnt == 4'd0) w_state_next = S_FIN;
            end
            S_FIN:   begin
                w_done       = 1'b1;
                w_state_next = bus.start ? S_GET_B : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // EXEC iterations minus one; the counter runs down to zero
    always_comb begin
        w_cnt_load = 4'd0;
        case (r_op)
            c_OP_SHL, c_OP_SHR:
                w_cnt_load = (bus.src_in[3:0] == 4'd0) ? 4'd0 : bus.src_in[3:0] - 4'd1;
`ifdef EXEC_UNIT_MUL_EN
            c_OP_MUL: w_cnt_load = 4'd15;
`endif
            default:  w_cnt_load = 4'd0;
        endcase
    end

    // Per-cycle datapath: result candidate and next working values
    always_comb begin
        w_res       = '0;
        w_c         = 1'b0;
        w_err       = 1'b0;
        w_work_next = r_work;
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
`ifdef EXEC_UNIT_MUL_EN
        w_psum     = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
                     (r_acc[0] ? {1'b0, r_a} : {(DATA_W+1){1'b0}});
        w_acc_next = {w_psum, r_acc[DATA_W-1:1]};
`endif
        case (r_op)
            c_OP_ADD: begin
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                w_res = r_a - r_b;
                w_c   = (r_a < r_b);
            end
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_SHL: begin
                // A zero count still spends one EXEC cycle but leaves A intact
                if (r_b[3:0] == 4'd0) begin
                    w_res = r_work;
                end else begin
                    w_work_next = {r_work[DATA_W-2:0], 1'b0};
                    w_res       = w_work_next;
                    w_c         = r_work[DATA_W-1];
                end
            end
            c_OP_SHR: begin
                if (r_b[3:0] == 4'd0) begin
                    w_res = r_work;
                end else begin
                    w_work_next = {1'b0, r_work[DATA_W-1:1]};
                    w_res       = w_work_next;
                    w_c         = r_work[0];
                end
            end
            c_OP_MUL: begin
`ifdef EXEC_UNIT_MUL_EN
                w_res = w_acc_next[DATA_W-1:0];
                w_c   = |w_acc_next[2*DATA_W-1:DATA_W];
`else
                w_err = 1'b1;
`endif
            end
            default: w_res = '0;
        endcase
    end

    // Operand capture and iteration bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= 3'd0;
            r_a    <= '0;
            r_b    <= '0;
            r_work <= '0;
            r_cnt  <= 4'd0;
`ifdef EXEC_UNIT_MUL_EN
            r_acc  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (bus.start) begin
                        r_a  <= bus.src_in;
                        r_op <= bus.opcode;
                    end
                end
                S_GET_B: begin
                    r_b    <= bus.src_in;
                    r_work <= r_a;
                    r_cnt  <= w_cnt_load;
`ifdef EXEC_UNIT_MUL_EN
                    r_acc  <= {{DATA_W{1'b0}}, bus.src_in};
`endif
                end
                S_EXEC: begin
                    r_work <= w_work_next;
`ifdef EXEC_UNIT_MUL_EN
                    r_acc  <= w_acc_next;
`endif
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Result and flags are written only on the final EXEC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_EXEC && r_cnt == 4'd0) begin
            r_result <= w_res;
            r_z      <= (w_res == '0);
            r_c      <= w_c;
            r_err    <= w_err;
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;
    assign bus.flag_z   = r_z;
    assign bus.flag_c   = r_c;
    assign bus.flag_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
//  Module      : tb_exec_unit
//  Description : Scoreboard bench for exec_unit. Issued operations push the
//                reference result into a queue; a monitor pops on DONE.
//                Build with EXEC_UNIT_MUL_EN to match a multiplier build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_unit;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        err;
        int          cycles;
        int          start_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];
    exp_t mon_e;

    exec_unit_if #(.DATA_W(16)) bus ();

    exec_unit #(.DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Reference behaviour straight from the operation definitions
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] w;
        int          n;
        n = int'(b[3:0]);
        e.res = 16'h0; e.c = 1'b0; e.err = 1'b0; e.cycles = 1; e.start_cyc = 0;
        case (op)
            3'd0: begin w = {16'h0, a} + {16'h0, b}; e.res = w[15:0]; e.c = w[16]; end
            3'd1: begin e.res = a - b; e.c = (a < b); end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: begin
                w = {16'h0, a} << n;
                e.res = w[15:0]; e.c = (n == 0) ? 1'b0 : w[16];
                e.cycles = (n == 0) ? 1 : n;
            end
            3'd6: begin
                w = {a, 16'h0} >> n;
                e.res = w[31:16]; e.c = (n == 0) ? 1'b0 : w[15];
                e.cycles = (n == 0) ? 1 : n;
            end
            default: begin
`ifdef EXEC_UNIT_MUL_EN
                w = 32'(a) * 32'(b);
                e.res = w[15:0]; e.c = |w[31:16]; e.cycles = 16;
`else
                e.res = 16'h0; e.err = 1'b1;
`endif
            end
        endcase
        e.z = (e.res == 16'h0);
        return e;
    endfunction

    // Scoreboard monitor: every DONE must match the oldest outstanding op
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no outstanding op");
            end else begin
                mon_e = q.pop_front();
                chk("result",   32'(bus.result),   32'(mon_e.res));
                chk("flag_z",   32'(bus.flag_z),   32'(mon_e.z));
                chk("flag_c",   32'(bus.flag_c),   32'(mon_e.c));
                chk("flag_err", 32'(bus.flag_err), 32'(mon_e.err));
                chk("latency",  32'(cyc - mon_e.start_cyc), 32'(mon_e.cycles + 2));
            end
        end
    end

    // Called one step after a rising edge with the DUT in IDLE or FIN;
    // returns one step into the first EXEC cycle.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int ncyc);
        exp_t e;
        e = model(op, a, b);
        e.start_cyc = cyc;
        ncyc = e.cycles;
        q.push_back(e);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.src_in = a;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.opcode = 3'($urandom);
        bus.src_in = b;
        chk("busy_in_get_b", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.src_in = 16'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done required done within 40 cycles");
        end
    endtask

    task automatic pulse_ignored_start();
        bus.start  = 1'b1;
        bus.opcode = 3'd0;
        bus.src_in = 16'($urandom);
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    initial begin : stim
        int          nc;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = 3'd0;
        bus.src_in = 16'h0;
        #1;
        chk("reset_busy",   32'(bus.busy),     32'd0);
        chk("reset_done",   32'(bus.done),     32'd0);
        chk("reset_result", 32'(bus.result),   32'd0);
        chk("reset_flags",  32'({bus.flag_z, bus.flag_c, bus.flag_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed corner cases
        issue(3'd0, 16'hFFFF, 16'h0001, nc); wait_done();
        issue(3'd1, 16'h0003, 16'h0005, nc); wait_done();   // back-to-back from FIN
        @(posedge clk); #1;
        issue(3'd5, 16'h8001, 16'h0004, nc); wait_done();
        issue(3'd6, 16'h8001, 16'h0000, nc); wait_done();
        issue(3'd7, 16'h0100, 16'h0100, nc); wait_done();
        @(posedge clk); #1;
        // START during EXEC must not disturb a long shift
        issue(3'd5, 16'h0003, 16'h0008, nc);
        pulse_ignored_start();
        wait_done();

        // Randomized traffic, mixing back-to-back and idle gaps
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 5))
                0: a = 16'hFFFF;
                1: b = 16'h0000;
                2: b = a;
                default: ;
            endcase
            issue(op, a, b, nc);
            if (nc >= 2 && $urandom_range(0, 1) == 1) pulse_ignored_start();
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
        end
        @(posedge clk); #1;

        // Make the result nonzero, then reset in the middle of a MUL
        issue(3'd3, 16'h1234, 16'h0001, nc); wait_done();
        @(posedge clk); #1;
        issue(3'd7, 16'h0100, 16'h0100, nc);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy",   32'(bus.busy),   32'd0);
        chk("async_rst_done",   32'(bus.done),   32'd0);
        chk("async_rst_result", 32'(bus.result), 32'd0);
        chk("async_rst_flags",  32'({bus.flag_z, bus.flag_c, bus.flag_err}), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        issue(3'd0, 16'h0002, 16'h0003, nc); wait_done();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
